iir_biquad_scheduler: RTL and testbench
=======================================

IIR_BIQUAD_SCHEDULER -- requirements
Module: iir_biquad_scheduler

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 18, signed coefficient width.
REQ-002 SHALL have parameter COEFF_SCALE, default 14, coefficient fractional bits (1.0 = 2^COEFF_SCALE).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed sample width.
REQ-004 SHALL have parameter COUNT_BITS, default 10, sample-rate divider width.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port div  input  COUNT_BITS  clk cycles per sample period.
REQ-008 SHALL have ports in_l, in_r  input  DATA_WIDTH each  signed left/right samples.
REQ-009 SHALL have ports out_l, out_r  output  DATA_WIDTH each  signed filtered samples.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse when out_l/out_r update.
REQ-011 SHALL have ports coef_valid (input, 1), coef_ready (output, 1), coef_addr (input, 3), coef_data (input, COEFF_WIDTH), forming the coefficient write handshake.
REQ-012 SHALL have port busy  output  1  high while the FSM is outside IDLE.
REQ-013 SHALL have ports overrun (output, 1, sticky dropped-tick flag) and overrun_clr (input, 1).

Function
REQ-014 SHALL implement one 2nd-order IIR per channel, both sharing one multiplier and one accumulator, with one product per cycle.
REQ-015 SHALL run a divider counter 0..div-1 and assert an internal tick when count==div-1; div==0 disables ticks and holds count at 0.
REQ-016 SHALL accept a tick only in IDLE, capturing in_l and in_r on that edge and entering MAC_L.
REQ-017 SHALL, on a tick outside IDLE, drop the tick, leave state unchanged, and set overrun; if set and overrun_clr coincide, set wins.
REQ-018 SHALL sequence IDLE -> MAC_L (5 cycles) -> STORE_L -> MAC_R (5 cycles) -> STORE_R -> DONE -> IDLE; busy is high for 13 cycles, so div>=14 avoids overrun.
REQ-019 SHALL, per channel, accumulate in this MAC order: B1*x0 + B2*x1 + B3*x2 - A2*y1 - A3*y2, where x0 is the captured sample.
REQ-020 SHALL use an accumulator of DATA_WIDTH+COEFF_WIDTH+3 bits, cleared at the start of each channel's MAC phase, with no intermediate overflow.
REQ-021 SHALL compute each result as acc arithmetically shifted right by COEFF_SCALE (floor), then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-022 SHALL, in STORE_x, update that channel's history: x2<=x1, x1<=x0, y2<=y1, y1<=saturated result.
REQ-023 SHALL update out_l and out_r together on the edge entering DONE, and assert out_valid only during DONE; latency is tick edge to out_valid = 13 cycles.
REQ-024 SHALL drive coef_ready = (state==IDLE) and perform a write when coef_valid && coef_ready.
REQ-025 SHALL map coef_addr 0..4 to B1, B2, B3, A2, A3; addr 5..7 SHALL be accepted with no effect.
REQ-026 SHALL share one coefficient set between both channels.
REQ-027 SHALL, when a write and an accepted tick occur in the same IDLE cycle, use the new coefficient for that sample.
REQ-028 SHALL hold out_l and out_r stable between DONE pulses.

Reset
REQ-029 SHALL, while reset_n==0 at a clk edge, force: state IDLE, count 0, all x/y histories 0, accumulator 0, out_l=out_r=0, out_valid=0, overrun=0, B1=2^COEFF_SCALE, B2=B3=A2=A3=0 (passthrough).
REQ-030 SHALL, when reset occurs mid-sequence, abandon the sample with no out_valid; the first tick after release restarts cleanly.
REQ-031 SHALL drive busy=0 and coef_ready=1 in the first cycle after reset release.

Verification
REQ-032 After reset, div=20, in_l=1000, in_r=-500 -> out_valid 13 cycles after each tick, out_l=1000, out_r=-500, overrun=0.
REQ-033 Write B1=B2=8192, others 0; step in_l from 0 to 1000 -> successive out_l values 500, then 1000.
REQ-034 Write B1=65536 (4.0), in_l=16000 / in_r=-16000 -> out_l=32767, out_r=-32768.
REQ-035 div=10 -> every second tick dropped, out_valid period 20 cycles, overrun=1 until an overrun_clr pulse.
REQ-036 Hold coef_valid during busy -> coef_ready=0 for 13 cycles, write completes in the first IDLE cycle, and the next sample uses the new value.
REQ-037 Pull reset_n low at MAC_R cycle 3 -> no out_valid, outputs 0, coefficients at defaults; the next sample is passthrough.

Source files
------------

// File: rtl/iir_biquad_scheduler.sv
// Stereo 2nd-order IIR: one shared multiplier/accumulator, five products per channel per sample.
// A sample-rate divider launches each sample; ticks that arrive while busy are dropped and flagged.
module iir_biquad_scheduler #(
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_SCALE = 14,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_BITS  = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [COUNT_BITS-1:0]         div,
  input  logic signed [DATA_WIDTH-1:0]  in_l,
  input  logic signed [DATA_WIDTH-1:0]  in_r,
  output logic signed [DATA_WIDTH-1:0]  out_l,
  output logic signed [DATA_WIDTH-1:0]  out_r,
  output logic                          out_valid,
  input  logic                          coef_valid,
  output logic                          coef_ready,
  input  logic [2:0]                    coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_data,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int unsigned ACC_W  = DATA_WIDTH + COEFF_WIDTH + 3;
  localparam int unsigned PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
  localparam logic signed [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(2 ** COEFF_SCALE);

  typedef enum logic [2:0] {IDLE, MAC_L, STORE_L, MAC_R, STORE_R, DONE} state_t;

  state_t state, state_next;
  logic [COUNT_BITS-1:0] count;
  logic                  tick;
  logic [2:0]            step;
  logic                  mac_en, acc_clr, busy_d, ready_d, valid_d;

  logic signed [COEFF_WIDTH-1:0] b1, b2, b3, a2, a3;
  logic signed [DATA_WIDTH-1:0]  x0_l, x1_l, x2_l, y1_l, y2_l;
  logic signed [DATA_WIDTH-1:0]  x0_r, x1_r, x2_r, y1_r, y2_r;

  logic signed [COEFF_WIDTH-1:0] mac_coef;
  logic signed [DATA_WIDTH-1:0]  mac_op;
  logic                          mac_sub;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc, shifted;
  logic signed [DATA_WIDTH-1:0]  sat_res;

  assign tick = (div != '0) && (count == div - COUNT_BITS'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (tick) state_next = MAC_L;
      MAC_L:   if (step == 3'd4) state_next = STORE_L;
      STORE_L: state_next = MAC_R;
      MAC_R:   if (step == 3'd4) state_next = STORE_R;
      STORE_R: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    mac_en  = (state == MAC_L) || (state == MAC_R);
    acc_clr = ((state == IDLE) && tick) || (state == STORE_L);
    busy_d  = (state_next != IDLE);
    ready_d = (state_next == IDLE);
    valid_d = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      coef_ready <= 1'b1;
      out_valid  <= 1'b0;
      step       <= 3'd0;
    end else begin
      busy       <= busy_d;
      coef_ready <= ready_d;
      out_valid  <= valid_d;
      step       <= (mac_en && step != 3'd4) ? step + 3'd1 : 3'd0;
    end
  end

  // Sample-rate divider and dropped-tick flag (set beats clear)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (div == '0)                         count <= '0;
      else if (count >= div - COUNT_BITS'(1)) count <= '0;
      else                                   count <= count + COUNT_BITS'(1);
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)      overrun <= 1'b0;
    end
  end

  // Coefficient bank shared by both channels; addresses 5..7 are accepted and ignored
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      b1 <= UNITY;
      b2 <= '0;
      b3 <= '0;
      a2 <= '0;
      a3 <= '0;
    end else if (coef_valid && coef_ready) begin
      case (coef_addr)
        3'd0:    b1 <= coef_data;
        3'd1:    b2 <= coef_data;
        3'd2:    b3 <= coef_data;
        3'd3:    a2 <= coef_data;
        3'd4:    a3 <= coef_data;
        default: ;
      endcase
    end
  end

  // Operand select: B1*x0 + B2*x1 + B3*x2 - A2*y1 - A3*y2
  always_comb begin
    mac_coef = b1;
    mac_op   = (state == MAC_R) ? x0_r : x0_l;
    mac_sub  = 1'b0;
    case (step)
      3'd1: begin mac_coef = b2; mac_op = (state == MAC_R) ? x1_r : x1_l; end
      3'd2: begin mac_coef = b3; mac_op = (state == MAC_R) ? x2_r : x2_l; end
      3'd3: begin mac_coef = a2; mac_op = (state == MAC_R) ? y1_r : y1_l; mac_sub = 1'b1; end
      3'd4: begin mac_coef = a3; mac_op = (state == MAC_R) ? y2_r : y2_l; mac_sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod    = PROD_W'(mac_coef) * PROD_W'(mac_op);
  assign shifted = acc >>> COEFF_SCALE;

  always_comb begin
    if (shifted > SAT_MAX)      sat_res = DATA_WIDTH'(SAT_MAX);
    else if (shifted < SAT_MIN) sat_res = DATA_WIDTH'(SAT_MIN);
    else                        sat_res = DATA_WIDTH'(shifted);
  end

  // Datapath: capture, accumulate, history update, output latch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc   <= '0;
      x0_l  <= '0; x1_l <= '0; x2_l <= '0; y1_l <= '0; y2_l <= '0;
      x0_r  <= '0; x1_r <= '0; x2_r <= '0; y1_r <= '0; y2_r <= '0;
      out_l <= '0;
      out_r <= '0;
    end else begin
      if (acc_clr)     acc <= '0;
      else if (mac_en) acc <= mac_sub ? acc - ACC_W'(prod) : acc + ACC_W'(prod);
      if (state == IDLE && tick) begin
        x0_l <= in_l;
        x0_r <= in_r;
      end
      if (state == STORE_L) begin
        x2_l <= x1_l; x1_l <= x0_l; y2_l <= y1_l; y1_l <= sat_res;
      end
      if (state == STORE_R) begin
        x2_r <= x1_r; x1_r <= x0_r; y2_r <= y1_r; y1_r <= sat_res;
        out_l <= y1_l;
        out_r <= sat_res;
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_scheduler.sv
// Directed bench for iir_biquad_scheduler: vector table of single-shot samples plus
// free-running divider, overrun, busy write-hold and mid-sequence reset sequences.
module tb_iir_biquad_scheduler;
  localparam int CW = 18;
  localparam int DW = 16;
  localparam int CB = 10;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [CB-1:0]        div;
  logic signed [DW-1:0] in_l, in_r, out_l, out_r;
  logic                 out_valid, coef_valid, coef_ready, busy, overrun, overrun_clr;
  logic [2:0]           coef_addr;
  logic signed [CW-1:0] coef_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iir_biquad_scheduler #(.COEFF_WIDTH(CW), .COEFF_SCALE(14), .DATA_WIDTH(DW), .COUNT_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n), .div(div), .in_l(in_l), .in_r(in_r),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  typedef struct {
    int b1, b2, b3, a2, a3;
    int il, ir;
    int el, er;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; div = '0; coef_valid = 1'b0; coef_addr = '0; coef_data = '0;
    overrun_clr = 1'b0; in_l = '0; in_r = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic write_coef(input logic [2:0] a, input int d);
    int k;
    @(posedge clk); #1;
    coef_valid = 1'b1; coef_addr = a; coef_data = CW'(d);
    k = 0;
    @(negedge clk);
    while (!coef_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1 coef_valid = 1'b0;
    if (k >= 50) check("coef_ready_timeout", k, 0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  // Single-shot sample: div=1 for one cycle gives exactly one tick
  task automatic fire(input int l, input int r, output int lat, output int ol, output int orr);
    wait_idle();
    @(posedge clk); #1;
    in_l = DW'(l); in_r = DW'(r); div = CB'(1);
    @(posedge clk); #1 div = '0;
    lat = 0; ol = 0; orr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k; ol = int'(out_l); orr = int'(out_r);
        break;
      end
    end
  endtask

  // Cycles (negedges) until out_valid, bounded
  task automatic cycles_to_valid(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, ol, orr, n, nb, nlow, pulses;

    vecs[0] = '{16384, 0, 0, 0, 0, 1000, -500, 1000, -500};
    vecs[1] = '{8192, 8192, 0, 0, 0, 0, 0, 500, -250};
    vecs[2] = '{8192, 8192, 0, 0, 0, 1000, -1000, 500, -500};
    vecs[3] = '{8192, 8192, 0, 0, 0, 1000, -1000, 1000, -1000};
    vecs[4] = '{65536, 0, 0, 0, 0, 16000, -16000, 32767, -32768};
    vecs[5] = '{16384, 0, 0, 8192, 0, 100, 0, -16284, 16384};
    vecs[6] = '{0, 0, 16384, 0, -4096, 0, 0, 24191, -24192};

    do_reset();
    @(negedge clk);
    check("rst_out_l", int'(out_l), 0);
    check("rst_out_r", int'(out_r), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_coef_ready", int'(coef_ready), 1);
    check("rst_overrun", int'(overrun), 0);

    // Free-running divider, passthrough coefficients
    @(posedge clk); #1;
    in_l = DW'(1000); in_r = -DW'(500); div = CB'(20);
    cycles_to_valid(n);
    check("fr_first_latency", n, 33);
    check("fr_out_l", int'(out_l), 1000);
    check("fr_out_r", int'(out_r), -500);
    n = 0; nb = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (out_valid) begin
        n = k;
        break;
      end
    end
    check("fr_period", n, 20);
    check("fr_busy_cycles", nb, 13);
    check("fr_overrun", int'(overrun), 0);
    @(posedge clk); #1 div = '0;
    repeat (30) @(negedge clk);

    // Vector table; each entry also writes junk to an unmapped address
    for (int i = 0; i < 7; i++) begin
      write_coef(3'd0, vecs[i].b1);
      write_coef(3'd1, vecs[i].b2);
      write_coef(3'd2, vecs[i].b3);
      write_coef(3'd3, vecs[i].a2);
      write_coef(3'd4, vecs[i].a3);
      write_coef(3'(5 + (i % 3)), 32'h15555);
      fire(vecs[i].il, vecs[i].ir, lat, ol, orr);
      check($sformatf("vec%0d_latency", i), lat, 13);
      check($sformatf("vec%0d_out_l", i), ol, vecs[i].el);
      check($sformatf("vec%0d_out_r", i), orr, vecs[i].er);
    end

    // div=10: every second tick dropped
    @(posedge clk); #1 div = CB'(10);
    cycles_to_valid(n);
    check("ov_first_seen", int'(n > 0), 1);
    cycles_to_valid(n);
    check("ov_period_a", n, 20);
    cycles_to_valid(n);
    check("ov_period_b", n, 20);
    check("ov_overrun_set", int'(overrun), 1);
    @(posedge clk); #1 div = '0;
    repeat (30) @(negedge clk);
    check("ov_overrun_sticky", int'(overrun), 1);
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    @(negedge clk);
    check("ov_overrun_cleared", int'(overrun), 0);

    // Coefficient write held across a busy period
    do_reset();
    @(negedge clk);
    @(posedge clk); #1;
    in_l = DW'(2000); in_r = -DW'(2000); div = CB'(1);
    @(posedge clk); #1;
    div = '0; coef_valid = 1'b1; coef_addr = 3'd0; coef_data = CW'(8192);
    nlow = 0; lat = 0; ol = 0; orr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k; ol = int'(out_l); orr = int'(out_r);
      end
      if (coef_ready) break;
      nlow++;
    end
    @(posedge clk); #1 coef_valid = 1'b0;
    check("hold_ready_low", nlow, 13);
    check("hold_latency", lat, 13);
    check("hold_old_out_l", ol, 2000);
    check("hold_old_out_r", orr, -2000);
    fire(2000, -2000, lat, ol, orr);
    check("hold_new_out_l", ol, 1000);
    check("hold_new_out_r", orr, -1000);

    // Reset during MAC_R cycle 3 (B1 currently 0.5)
    wait_idle();
    @(posedge clk); #1;
    in_l = DW'(3000); in_r = -DW'(3000); div = CB'(1);
    @(posedge clk); #1 div = '0;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("mr_busy_before_reset", int'(busy), 1);
    @(posedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("mr_busy", int'(busy), 0);
    check("mr_coef_ready", int'(coef_ready), 1);
    check("mr_out_l", int'(out_l), 0);
    check("mr_out_r", int'(out_r), 0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("mr_no_valid", pulses, 0);
    fire(1234, -4321, lat, ol, orr);
    check("mr_latency", lat, 13);
    check("mr_pass_l", ol, 1234);
    check("mr_pass_r", orr, -4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
